// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a programmable clocks-per-bit divider, feeding a
// small byte FIFO with sticky overrun / framing-error flags.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ser_rx,
    input  logic [DIV_WIDTH-1:0]          cfg_divider,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                 rx_m, rx_s;
    logic [1:0]           state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div, half;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic                 stop_tick, push, fe_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, do_push, ovr_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= ser_rx;
            rx_s <= rx_m;
        end
    end

    assign div  = (cfg_divider < TWO) ? TWO : cfg_divider;
    assign half = div >> 1;

    // The stop sample pushes combinationally so the byte is visible the very next cycle.
    assign stop_tick = (state == S_STOP) && (cnt == div - ONE);
    assign push      = stop_tick && rx_s;
    assign fe_set    = stop_tick && !rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (cnt == half - ONE) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                S_DATA: begin
                    if (cnt == div - ONE) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    if (stop_tick) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
            endcase
        end
    end

    assign full     = (fifo_level == LW'(FIFO_DEPTH));
    assign rd_valid = (fifo_level != '0);
    assign pop      = rd_en && rd_valid;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign do_push  = push && (!full || pop);
    assign ovr_set  = push && full && !pop;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(do_push) - LW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ovr_set || (overrun && !err_clr);
            frame_err <= fe_set || (frame_err && !err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: serial frames driven bit by bit, a queue
// model of the FIFO contents and flags, and a monitor that checks every pop.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ser_rx;
    logic [31:0] cfg_divider;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [2:0]  fifo_level;
    logic        overrun;
    logic        frame_err;
    logic        err_clr;

    logic [7:0] exp_q[$];
    logic       exp_ovr;
    logic       exp_fe;
    int         checks;
    int         failures;

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .ser_rx(ser_rx), .cfg_divider(cfg_divider),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_level(fifo_level), .overrun(overrun), .frame_err(frame_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must return the model's oldest byte.
    always @(negedge clk) begin
        if (!reset && rd_en && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("pop_on_empty_model", 32'(rd_data), 32'hxxxx_xxxx);
            end else begin
                chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state(input string name);
        @(negedge clk);
        chk({name, ".rd_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
        chk({name, ".level"}, 32'(fifo_level), 32'(exp_q.size()));
        chk({name, ".overrun"}, 32'(overrun), 32'(exp_ovr));
        chk({name, ".frame_err"}, 32'(frame_err), 32'(exp_fe));
        if (exp_q.size() != 0) chk({name, ".rd_data"}, 32'(rd_data), 32'(exp_q[0]));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        chk({name, ".rd_valid"}, 32'(rd_valid), 32'd0);
        chk({name, ".level"}, 32'(fifo_level), 32'd0);
        chk({name, ".rd_data"}, 32'(rd_data), 32'd0);
        chk({name, ".overrun"}, 32'(overrun), 32'd0);
        chk({name, ".frame_err"}, 32'(frame_err), 32'd0);
    endtask

    function automatic logic line_bit(input logic [7:0] data, input logic stop_bit, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        if (b == 9) return stop_bit;
        return 1'b1;
    endfunction

    // Drives one frame; ser_rx is first low at the edge after the call.
    // The stop sample lands on edge 2 + half + 9*div counted from that edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int div_cfg,
                              input bit pop_at_stop, input bit clr_at_stop, input bit chk_timing);
        int d, half, se, n0;
        d    = (div_cfg < 2) ? 2 : div_cfg;
        half = d / 2;
        se   = 9 * d + 2 + half;
        n0   = exp_q.size();
        cfg_divider = 32'(div_cfg);
        for (int k = 0; k <= 10 * d + 2; k++) begin
            ser_rx  = line_bit(data, stop_bit, k / d);
            rd_en   = pop_at_stop && (k == se);
            err_clr = clr_at_stop && (k == se);
            if (chk_timing && (k == se || k == se + 1)) begin
                @(negedge clk);
                chk(k == se ? "level_before_stop" : "level_after_stop",
                    32'(fifo_level), 32'(k == se ? n0 : n0 + 1));
            end
            @(posedge clk); #1;
        end
        rd_en = 1'b0; err_clr = 1'b0; ser_rx = 1'b1;
        if (clr_at_stop) begin exp_ovr = 1'b0; exp_fe = 1'b0; end
        if (!stop_bit) exp_fe = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(data);
        else exp_ovr = 1'b1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        exp_ovr = 1'b0; exp_fe = 1'b0;
        reset = 1'b1; ser_rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0; cfg_divider = 32'd10;
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Basic frame with exact visibility timing
        send_frame(8'hA5, 1'b1, 10, 1'b0, 1'b0, 1'b1);
        check_state("a5");
        pop_one();
        check_state("a5_popped");

        // Start-bit glitch is ignored
        ser_rx = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ser_rx = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check_state("glitch");
        send_frame(8'h3C, 1'b1, 10, 1'b0, 1'b0, 1'b0);
        check_state("3c");
        pop_one();

        // Framing error, clear, and set-wins-over-clear
        send_frame(8'h55, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        check_state("fe_set");
        clear_errors();
        check_state("fe_cleared");
        send_frame(8'h55, 1'b0, 10, 1'b0, 1'b1, 1'b0);
        check_state("fe_set_wins");
        clear_errors();

        // Overrun with no reads
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 10, 1'b0, 1'b0, 1'b0);
        check_state("overrun");
        repeat (4) pop_one();
        check_state("drained");
        pop_one();
        check_state("pop_empty_ignored");
        clear_errors();

        // Pop on the exact cycle a byte lands into a full FIFO
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 10, 1'b0, 1'b0, 1'b0);
        send_frame(8'h05, 1'b1, 10, 1'b1, 1'b0, 1'b0);
        check_state("full_pop_push");
        repeat (4) pop_one();
        check_state("full_pop_push_drained");

        // Reset mid-frame, then a fresh frame; divider 0 acts as 2
        send_frame(8'h77, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check_state("div0");
        cfg_divider = 32'd10;
        for (int k = 0; k <= 102; k++) begin
            ser_rx = line_bit(8'hFF, 1'b1, k / 10);
            if (k == 40) reset = 1'b1;
            if (k == 43) reset = 1'b0;
            if (k == 41) check_reset_outputs("reset_mid_frame");
            @(posedge clk); #1;
        end
        exp_q.delete(); exp_ovr = 1'b0; exp_fe = 1'b0;
        check_state("after_reset");
        send_frame(8'h81, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        check_state("81");
        pop_one();

        // Randomised traffic
        for (int n = 0; n < 25; n++) begin
            send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 12),
                       1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) pop_one();
            if ($urandom_range(0, 5) == 0) clear_errors();
            check_state("random");
        end
        while (exp_q.size() != 0) pop_one();
        check_state("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- SoC-side serial receiver for the ser_rx line. It is the receiving end of the UART stream the emulation UART transactor drives into the design.
- Deserialises 8N1 frames at a programmable clocks-per-bit divider and buffers received bytes in a small FIFO.
- The CPU bus wrapper pops bytes from the FIFO and reads sticky error flags.
- Sits beside the SoC UART transmitter and shares the same divider register.

Parameters:
- FIFO_DEPTH, 4, number of buffered bytes; power of two, minimum 2.
- DIV_WIDTH, 32, width of cfg_divider.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- ser_rx  input  1  asynchronous serial input, idle high
- cfg_divider  input  DIV_WIDTH  clocks per bit; values below 2 treated as 2
- rd_en  input  1  pop request for FIFO head
- rd_data  output  8  FIFO head byte; valid while rd_valid is high
- rd_valid  output  1  FIFO not empty
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
- overrun  output  1  sticky: a byte was dropped because the FIFO was full
- frame_err  output  1  sticky: stop bit sampled low
- err_clr  input  1  clears overrun and frame_err

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; bit/clock counters go to 0.
  - Synchroniser flops reset to 1 (idle).
  - FIFO empties; rd_valid=0, fifo_level=0, rd_data=0, overrun=0, frame_err=0.
  - A frame in progress when reset asserts is discarded entirely.
- Input synchronisation:
  - ser_rx passes through a 2-flop synchroniser to give rx_s.
  - rx_s lags ser_rx by 2 clock edges.
- Effective divider: div = max(cfg_divider, 2); half = div>>1.
- cfg_divider is read continuously. Changing it mid-frame is undefined; it is changed only while the receiver is idle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: at the first edge where rx_s==0 (edge E0), go to START with cnt=0.
  - START: cnt counts up each clock. At E0+half, sample rx_s.
    - rx_s==1: glitch; return to IDLE, nothing recorded.
    - rx_s==0: go to DATA, bit index 0, cnt=0.
  - DATA: sample one bit every div clocks, LSB first. Bit i is sampled at E0+half+(i+1)*div. After bit 7, go to STOP.
  - STOP: sample at E0+half+9*div.
    - rx_s==1: push the byte to the FIFO.
    - rx_s==0: set frame_err, discard the byte.
    - Either way, return to IDLE in the same edge. A new start bit can be detected from the next cycle.
- FIFO:
  - A push becomes visible the cycle after the stop sample: rd_valid=1, rd_data=byte, fifo_level increments.
  - rd_data is the registered head entry and is stable while no pop occurs.
  - rd_en with rd_valid=1 pops; the next entry (or empty) is visible the following cycle.
  - rd_en while empty is ignored.
  - Push while full and no pop in the same cycle: the byte is dropped, overrun=1, FIFO contents unchanged.
  - Push and pop in the same cycle while full: pop then push; level unchanged, no overrun.
  - Push and pop in the same cycle while empty: the pop is ignored; level goes to 1.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level distinguishes full from empty.
- Errors:
  - overrun and frame_err stay set until err_clr.
  - If a set and err_clr happen in the same cycle, the flag ends set (set wins).

Test Plan:
1. cfg_divider=10; send 0xA5 as 8N1 with ser_rx first low at edge 0 -> rd_valid rises after edge 97 (2+5+90); rd_data=0xA5; fifo_level=1; no error flags.
2. cfg_divider=10; drive ser_rx low for 3 clocks then high -> FSM returns to IDLE at the START sample; rd_valid stays 0; no flags. Then send 0x3C -> received correctly.
3. Send 0x55 with the stop bit held low -> frame_err=1, FIFO stays empty. Pulse err_clr -> frame_err=0 next cycle. Pulse err_clr in the same cycle as a new frame error -> frame_err remains 1.
4. FIFO_DEPTH=4; send 0x01..0x05 back-to-back with no reads -> fifo_level=4, overrun=1; pops return 0x01,0x02,0x03,0x04, then rd_valid=0.
5. Full FIFO; assert rd_en on the exact cycle a 5th byte completes -> no overrun; level stays 4; order 0x02..0x05 preserved.
6. Assert reset midway through the DATA bits of 0xFF, release, then send 0x81 -> only 0x81 appears; all outputs at reset values during reset. cfg_divider=0 behaves identically to cfg_divider=2.
